// File: rtl/layer_wr_ctl_if.sv
// Byte-stream and RAM write-port bundle for the LED cube layer write controller.
// master drives the SPI byte side, slave is the controller.
interface layer_wr_ctl_if #(
  parameter int LAYERS = 8,
  parameter int LEDS   = 64,
  parameter int COLORS = 3
);
  localparam int AW = $clog2(LEDS);

  logic              dc_in;
  logic              byte_rdy_in;
  logic [7:0]        byte_data_in;
  logic              frame_rdy_out;
  logic [AW-1:0]     wr_addr_out;
  logic [COLORS:0]   byte_en_out;
  logic [LAYERS-1:0] layer_en_out;
  logic              ovf_out;

  modport master (
    output dc_in, byte_rdy_in, byte_data_in,
    input  frame_rdy_out, wr_addr_out, byte_en_out, layer_en_out, ovf_out
  );

  modport slave (
    input  dc_in, byte_rdy_in, byte_data_in,
    output frame_rdy_out, wr_addr_out, byte_en_out, layer_en_out, ovf_out
  );
endinterface

// File: rtl/layer_wr_ctl.sv
// Command/data decoder driving LED cube layer RAM write address, lane and layer enables.
// Define LAYER_WR_CTL_OVF_EN to enable the sticky overrun flag (otherwise ovf_out stays 0).
module layer_wr_ctl #(
  parameter int         LAYERS        = 8,
  parameter int         LEDS          = 64,
  parameter int         COLORS        = 3,
  parameter logic [7:0] CMD_ADDR_WR   = 8'hcc,
  parameter logic [7:0] CMD_DATA_WR   = 8'hda,
  parameter logic [7:0] CMD_LAYER_SEL = 8'hc0
) (
  input logic           clk_in,
  input logic           rst_in,
  layer_wr_ctl_if.slave bus
);
  localparam int              AW        = $clog2(LEDS);
  localparam int              LW        = $clog2(LAYERS);
  localparam logic [AW-1:0]   ADDR_LAST = AW'(LEDS - 1);
  localparam logic [AW-1:0]   ADDR_ONE  = AW'(1);
  localparam logic [7:0]      LAYERS_B  = 8'(LAYERS);
  localparam logic [LW-1:0]   START_RST = LW'(LAYERS - 1);

  typedef enum logic [2:0] {IDLE, ADDR, DATA, SEL, DONE} state_t;

  state_t            state_q, state_n;
  logic [AW-1:0]     addr_q, addr_n;
  logic [COLORS:0]   be_q, be_n;
  logic [LAYERS-1:0] lay_q, lay_n;
  logic [LW-1:0]     start_q, start_n;
  logic              frame_q, frame_n;
  logic              ovf_q, ovf_n;
  logic              last_addr, last_lane, oor;

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      addr_q  <= '0;
      be_q    <= '0;
      lay_q   <= '0;
      start_q <= START_RST;
      frame_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_n;
      addr_q  <= addr_n;
      be_q    <= be_n;
      lay_q   <= lay_n;
      start_q <= start_n;
      frame_q <= frame_n;
      ovf_q   <= ovf_n;
    end
  end

  always_comb begin
    state_n   = state_q;
    addr_n    = addr_q;
    be_n      = be_q;
    lay_n     = lay_q;
    start_n   = start_q;
    frame_n   = 1'b0;
    ovf_n     = ovf_q;
    last_addr = (addr_q == ADDR_LAST);
    last_lane = be_q[0];
    oor       = (bus.byte_data_in >= LAYERS_B);
    if (bus.byte_rdy_in) begin
      if (!bus.dc_in) begin
        // Any command restarts the write path and drops an unfinished frame silently
        addr_n = '0;
        ovf_n  = 1'b0;
        be_n   = '0;
        lay_n  = '0;
        case (bus.byte_data_in)
          CMD_ADDR_WR: begin
            state_n      = ADDR;
            be_n[COLORS] = 1'b1;
            lay_n        = '1;
          end
          CMD_DATA_WR: begin
            state_n          = DATA;
            be_n[COLORS-1]   = 1'b1;
            lay_n[start_q]   = 1'b1;
          end
          CMD_LAYER_SEL: state_n = SEL;
          default:       state_n = IDLE;
        endcase
      end else begin
        case (state_q)
          ADDR: begin
            if (last_addr) begin
              addr_n  = '0;
              lay_n   = '0;
              state_n = DONE;
            end else begin
              addr_n = addr_q + ADDR_ONE;
            end
          end
          DATA: begin
            // Rotate colour lanes right, LSB wraps to MSB
            for (int i = 0; i < COLORS; i++) be_n[i] = be_q[(i + 1) % COLORS];
            if (last_lane) begin
              if (last_addr) begin
                addr_n = '0;
                lay_n  = lay_q >> 1;
                if (lay_q[0]) begin
                  frame_n = 1'b1;
                  state_n = DONE;
                end
              end else begin
                addr_n = addr_q + ADDR_ONE;
              end
            end
          end
          SEL: begin
            state_n = IDLE;
            if (oor) begin
              start_n = START_RST;
`ifdef LAYER_WR_CTL_OVF_EN
              ovf_n   = 1'b1;
`endif
            end else begin
              start_n = bus.byte_data_in[LW-1:0];
            end
          end
          DONE: begin
`ifdef LAYER_WR_CTL_OVF_EN
            ovf_n = 1'b1;
`endif
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.wr_addr_out   = addr_q;
  assign bus.byte_en_out   = be_q;
  assign bus.layer_en_out  = bus.byte_rdy_in ? lay_q : '0;
  assign bus.frame_rdy_out = frame_q;
`ifdef LAYER_WR_CTL_OVF_EN
  assign bus.ovf_out       = ovf_q;
`else
  assign bus.ovf_out       = 1'b0;
`endif
endmodule
